// File: rtl/turf_event_fragmenter.sv
// turf_event_fragmenter: splits each 64-bit event stream into UDP fragments (header word + payload qwords).
// Latency: UDP header valid 2 cycles after the event header handshake; payload is a same-cycle passthrough.
// Backpressure: payload tready follows m_udpdata_tready in FRAG_DATA; headers, tags and pads wait on their own tready.
// Build option: define TURF_EVENT_FRAG_TAG_EN to prefix every fragment with a tag qword counted in the UDP length.
module turf_event_fragmenter #(
   parameter int LEN_BITS = 20,
   parameter int CNT_BITS = 16
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic [63:0]         s_evhdr_tdata,
   input  logic                s_evhdr_tvalid,
   output logic                s_evhdr_tready,
   input  logic [63:0]         s_evdata_tdata,
   input  logic [7:0]          s_evdata_tkeep,
   input  logic                s_evdata_tlast,
   input  logic                s_evdata_tvalid,
   output logic                s_evdata_tready,
   output logic [63:0]         m_udphdr_tdata,
   output logic                m_udphdr_tvalid,
   input  logic                m_udphdr_tready,
   output logic [63:0]         m_udpdata_tdata,
   output logic [7:0]          m_udpdata_tkeep,
   output logic                m_udpdata_tlast,
   output logic                m_udpdata_tvalid,
   input  logic                m_udpdata_tready,
   input  logic [9:0]          nfragment_count_i,
   input  logic [31:0]         event_ip_i,
   input  logic [15:0]         event_port_i,
   input  logic                event_open_i,
   output logic [CNT_BITS-1:0] drop_count_o,
   output logic [CNT_BITS-1:0] err_count_o,
   output logic                busy_o
);

`ifdef TURF_EVENT_FRAG_TAG_EN
   localparam bit TAG_EN = 1'b1;
`else
   localparam bit TAG_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, LATCH, FRAG_HDR, FRAG_TAG, FRAG_DATA, PAD, DUMP} state_t;

   state_t              state;
   logic [31:0]         hdr_num;      // event number held between header handshake and LATCH
   logic [LEN_BITS-1:0] hdr_len;
   logic [31:0]         evnum_q;
   logic [31:0]         ip_q;
   logic [15:0]         port_q;
   logic [15:0]         frag_idx;
   logic [LEN_BITS-1:0] remaining;    // qwords of the event not yet forwarded
   logic [10:0]         nplus1;       // max qwords per fragment, 1..1024
   logic [10:0]         p_q;          // size of the fragment in flight
   logic                last_q;       // fragment in flight is the final one of the event
   logic [9:0]          beat;         // beat index inside the current fragment

   logic [10:0]         p_cur;
   logic [9:0]          p_m1;
   logic [15:0]         udp_len;
   logic                beat_last;
   logic                final_beat;
   logic                unused_hdr_bits;

   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
      return (v == '1) ? v : v + CNT_BITS'(1);
   endfunction

   // fragment sizing and beat bookkeeping derived from registered state
   always_comb begin
      p_cur           = (remaining < LEN_BITS'(nplus1)) ? remaining[10:0] : nplus1;
      p_m1            = 10'(p_q - 11'd1);
      udp_len         = {2'b00, p_cur, 3'b000} + (TAG_EN ? 16'd8 : 16'd0);
      beat_last       = (beat == p_m1);
      final_beat      = (remaining == LEN_BITS'(1));
      unused_hdr_bits = ^s_evhdr_tdata[31:LEN_BITS];
   end

   // handshake and data outputs decoded from the registered state
   always_comb begin
      s_evhdr_tready   = (state == IDLE) && !areset;
      s_evdata_tready  = 1'b0;
      m_udphdr_tvalid  = 1'b0;
      m_udphdr_tdata   = {ip_q, port_q, udp_len};
      m_udpdata_tvalid = 1'b0;
      m_udpdata_tdata  = 64'd0;
      m_udpdata_tkeep  = 8'h00;
      m_udpdata_tlast  = 1'b0;
      busy_o           = (state != IDLE);
      case (state)
         FRAG_HDR: m_udphdr_tvalid = 1'b1;
         FRAG_TAG: begin
            m_udpdata_tvalid = 1'b1;
            m_udpdata_tdata  = {evnum_q, frag_idx, last_q, 5'b00000, p_m1};
            m_udpdata_tkeep  = 8'hFF;
         end
         FRAG_DATA: begin
            m_udpdata_tvalid = s_evdata_tvalid;
            s_evdata_tready  = m_udpdata_tready;
            m_udpdata_tdata  = s_evdata_tdata;
            m_udpdata_tkeep  = final_beat ? s_evdata_tkeep : 8'hFF;
            m_udpdata_tlast  = beat_last;
         end
         PAD: begin
            m_udpdata_tvalid = 1'b1;
            m_udpdata_tkeep  = 8'hFF;
            m_udpdata_tlast  = beat_last;
         end
         DUMP:    s_evdata_tready = 1'b1;
         default: ;
      endcase
   end

   // fragmenter state machine, captured config and saturating counters
   always_ff @(posedge aclk) begin
      if (areset) begin
         state        <= IDLE;
         hdr_num      <= '0;
         hdr_len      <= '0;
         evnum_q      <= '0;
         ip_q         <= '0;
         port_q       <= '0;
         frag_idx     <= '0;
         remaining    <= '0;
         nplus1       <= '0;
         p_q          <= '0;
         last_q       <= 1'b0;
         beat         <= '0;
         drop_count_o <= '0;
         err_count_o  <= '0;
      end else begin
         case (state)
            IDLE: if (s_evhdr_tvalid) begin
               hdr_num <= s_evhdr_tdata[63:32];
               hdr_len <= s_evhdr_tdata[LEN_BITS-1:0];
               state   <= LATCH;
            end
            LATCH: begin
               evnum_q   <= hdr_num;
               remaining <= hdr_len;
               nplus1    <= {1'b0, nfragment_count_i} + 11'd1;
               ip_q      <= event_ip_i;
               port_q    <= event_port_i;
               frag_idx  <= '0;
               if (!event_open_i) begin
                  drop_count_o <= sat_inc(drop_count_o);
                  state        <= DUMP;
               end else if (hdr_len == '0) begin
                  err_count_o <= sat_inc(err_count_o);
                  state       <= DUMP;
               end else begin
                  state <= FRAG_HDR;
               end
            end
            FRAG_HDR: if (m_udphdr_tready) begin
               p_q    <= p_cur;
               last_q <= (remaining <= LEN_BITS'(nplus1));
               beat   <= '0;
               state  <= TAG_EN ? FRAG_TAG : FRAG_DATA;
            end
            FRAG_TAG: if (m_udpdata_tready) state <= FRAG_DATA;
            FRAG_DATA: if (s_evdata_tvalid && m_udpdata_tready) begin
               remaining <= remaining - LEN_BITS'(1);
               beat      <= beat + 10'd1;
               if (s_evdata_tlast && !final_beat) begin
                  // source ended early: finish this fragment with zeros, then stop
                  err_count_o <= sat_inc(err_count_o);
                  state       <= beat_last ? IDLE : PAD;
               end else if (final_beat) begin
                  if (!s_evdata_tlast) begin
                     // source runs past the advertised length: drain the excess
                     err_count_o <= sat_inc(err_count_o);
                     state       <= DUMP;
                  end else begin
                     state <= IDLE;
                  end
               end else if (beat_last) begin
                  frag_idx <= frag_idx + 16'd1;
                  state    <= FRAG_HDR;
               end
            end
            PAD: if (m_udpdata_tready) begin
               beat <= beat + 10'd1;
               if (beat_last) state <= IDLE;
            end
            DUMP: if (s_evdata_tvalid && s_evdata_tlast) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_turf_event_fragmenter.sv
// tb_turf_event_fragmenter: table of events driven through the fragmenter, outputs scored against a queue model.
// Latency: header/data drivers and a negedge monitor run concurrently; each event waits for drain before the next.
// Backpressure: optional random ready/valid gaps on m_* tready and s_evdata tvalid.
module tb_turf_event_fragmenter;

`ifdef TURF_EVENT_FRAG_TAG_EN
   localparam int TAG = 1;
`else
   localparam int TAG = 0;
`endif

   logic        aclk = 1'b0;
   logic        areset;
   logic [63:0] s_evhdr_tdata;
   logic        s_evhdr_tvalid;
   logic        s_evhdr_tready;
   logic [63:0] s_evdata_tdata;
   logic [7:0]  s_evdata_tkeep;
   logic        s_evdata_tlast;
   logic        s_evdata_tvalid;
   logic        s_evdata_tready;
   logic [63:0] m_udphdr_tdata;
   logic        m_udphdr_tvalid;
   logic        m_udphdr_tready;
   logic [63:0] m_udpdata_tdata;
   logic [7:0]  m_udpdata_tkeep;
   logic        m_udpdata_tlast;
   logic        m_udpdata_tvalid;
   logic        m_udpdata_tready;
   logic [9:0]  nfragment_count_i;
   logic [31:0] event_ip_i;
   logic [15:0] event_port_i;
   logic        event_open_i;
   logic [15:0] drop_count_o;
   logic [15:0] err_count_o;
   logic        busy_o;

   turf_event_fragmenter #(.LEN_BITS(20), .CNT_BITS(16)) dut (
      .aclk(aclk), .areset(areset),
      .s_evhdr_tdata(s_evhdr_tdata), .s_evhdr_tvalid(s_evhdr_tvalid), .s_evhdr_tready(s_evhdr_tready),
      .s_evdata_tdata(s_evdata_tdata), .s_evdata_tkeep(s_evdata_tkeep), .s_evdata_tlast(s_evdata_tlast),
      .s_evdata_tvalid(s_evdata_tvalid), .s_evdata_tready(s_evdata_tready),
      .m_udphdr_tdata(m_udphdr_tdata), .m_udphdr_tvalid(m_udphdr_tvalid), .m_udphdr_tready(m_udphdr_tready),
      .m_udpdata_tdata(m_udpdata_tdata), .m_udpdata_tkeep(m_udpdata_tkeep), .m_udpdata_tlast(m_udpdata_tlast),
      .m_udpdata_tvalid(m_udpdata_tvalid), .m_udpdata_tready(m_udpdata_tready),
      .nfragment_count_i(nfragment_count_i), .event_ip_i(event_ip_i), .event_port_i(event_port_i),
      .event_open_i(event_open_i), .drop_count_o(drop_count_o), .err_count_o(err_count_o), .busy_o(busy_o)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      bit         open;
      int         n;
      int         len;
      int         nbeats;
      logic [7:0] kl;
      bit         gaps;
   } vec_t;

   vec_t        vecs[9];
   logic [63:0] hq[$];
   logic [72:0] dq[$];
   int          tests = 0;
   int          fails = 0;
   int          exp_drop = 0;
   int          exp_err = 0;
   bit          rand_rdy = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // expected UDP headers and payload beats for one event
   task automatic model_event(input bit open, input int n, input int len, input int nbeats,
                              input logic [7:0] kl, input logic [31:0] evn,
                              input logic [31:0] ip, input logic [15:0] port);
      int rem, di, idx, p;
      bit shrt, lst;
      logic [7:0] k;
      if (!open) begin exp_drop++; return; end
      if (len == 0) begin exp_err++; return; end
      rem = len; di = 0; idx = 0; shrt = 1'b0;
      while (rem > 0 && !shrt) begin
         p   = (rem < n + 1) ? rem : n + 1;
         lst = (rem <= n + 1);
         hq.push_back({ip, port, 16'(8 * (p + TAG))});
         if (TAG != 0) dq.push_back({evn, 16'(idx), lst, 5'b00000, 10'(p - 1), 8'hFF, 1'b0});
         for (int k2 = 0; k2 < p; k2++) begin
            if (shrt) begin
               dq.push_back({64'd0, 8'hFF, (k2 == p - 1)});
            end else begin
               k = (rem == 1 && di == nbeats - 1) ? kl : 8'hFF;
               dq.push_back({evn, 32'(di), k, (k2 == p - 1)});
               di++; rem--;
               if (di == nbeats && rem > 0) shrt = 1'b1;
            end
         end
         idx++;
      end
      if (shrt || nbeats > len) exp_err++;
   endtask

   task automatic send_hdr(input logic [31:0] evn, input logic [19:0] len);
      int c = 0;
      s_evhdr_tdata  = {evn, 12'h000, len};
      s_evhdr_tvalid = 1'b1;
      @(negedge aclk);
      while (!s_evhdr_tready && c < 200) begin @(negedge aclk); c++; end
      @(posedge aclk); #1;
      s_evhdr_tvalid = 1'b0;
      tests++;
      if (c >= 200) begin fails++; $display("FAIL evhdr_accept actual=timeout required=handshake"); end
   endtask

   task automatic send_data(input logic [31:0] evn, input int nbeats, input int stop,
                            input logic [7:0] kl, input bit gaps);
      int c;
      for (int i = 0; i < stop; i++) begin
         if (gaps) begin
            s_evdata_tvalid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
         end
         s_evdata_tdata  = {evn, 32'(i)};
         s_evdata_tkeep  = (i == nbeats - 1) ? kl : 8'hFF;
         s_evdata_tlast  = (i == nbeats - 1);
         s_evdata_tvalid = 1'b1;
         c = 0;
         @(negedge aclk);
         while (!s_evdata_tready && c < 500) begin @(negedge aclk); c++; end
         if (c >= 500) begin
            tests++; fails++;
            $display("FAIL evdata_accept beat=%0d actual=timeout required=handshake", i);
            s_evdata_tvalid = 1'b0;
            return;
         end
         @(posedge aclk); #1;
      end
      s_evdata_tvalid = 1'b0;
      s_evdata_tlast  = 1'b0;
   endtask

   task automatic wait_idle(input int id);
      int c = 0;
      @(negedge aclk);
      while ((busy_o || hq.size() != 0 || dq.size() != 0) && c < 5000) begin @(negedge aclk); c++; end
      tests++;
      if (c >= 5000) begin
         fails++;
         $display("FAIL drain_ev%0d actual=busy%0d/hq%0d/dq%0d required=idle/0/0", id, busy_o, hq.size(), dq.size());
      end
      @(posedge aclk); #1;
   endtask

   task automatic run_vec(input vec_t v, input int id);
      logic [31:0] evn, ip;
      logic [15:0] port;
      evn = 32'h1000 + id; ip = 32'hC0A80100 + id; port = 16'(5000 + id);
      event_ip_i = ip; event_port_i = port; event_open_i = v.open; nfragment_count_i = 10'(v.n);
      rand_rdy = v.gaps;
      model_event(v.open, v.n, v.len, v.nbeats, v.kl, evn, ip, port);
      fork
         begin
            send_hdr(evn, 20'(v.len));
            // config changes after LATCH must not affect the event in flight
            repeat (2) @(posedge aclk);
            #1;
            event_ip_i = 32'hDEADBEEF; event_port_i = 16'hFFFF;
            nfragment_count_i = 10'd2; event_open_i = ~v.open;
         end
         send_data(evn, v.nbeats, v.nbeats, v.kl, v.gaps);
      join
      wait_idle(id);
      rand_rdy = 1'b0;
      check($sformatf("drop_count_ev%0d", id), 64'(drop_count_o), 64'(exp_drop));
      check($sformatf("err_count_ev%0d", id), 64'(err_count_o), 64'(exp_err));
   endtask

   // downstream ready generator
   initial begin
      forever begin
         @(posedge aclk); #1;
         m_udphdr_tready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         m_udpdata_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // scoreboard: every output handshake must match the head of its queue
   always @(negedge aclk) begin
      if (m_udphdr_tvalid && m_udphdr_tready) begin
         tests++;
         if (hq.size() == 0) begin
            fails++;
            $display("FAIL udphdr_extra actual=%h required=none", m_udphdr_tdata);
         end else if (m_udphdr_tdata !== hq[0]) begin
            fails++;
            $display("FAIL udphdr actual=%h required=%h", m_udphdr_tdata, hq[0]);
            void'(hq.pop_front());
         end else begin
            void'(hq.pop_front());
         end
      end
      if (m_udpdata_tvalid && m_udpdata_tready) begin
         tests++;
         if (dq.size() == 0) begin
            fails++;
            $display("FAIL udpdata_extra actual=%h/%h/%b required=none", m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast);
         end else if ({m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast} !== dq[0]) begin
            fails++;
            $display("FAIL udpdata actual=%h required=%h", {m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast}, dq[0]);
            void'(dq.pop_front());
         end else begin
            void'(dq.pop_front());
         end
      end
   end

   initial begin
      vec_t fresh;
      //            open  N     len   beats kl     gaps
      vecs[0] = '{1'b1, 127,  300,  300,  8'h0F, 1'b0};  // three fragments
      vecs[1] = '{1'b0, 127,  50,   50,   8'hFF, 1'b0};  // link closed: dropped
      vecs[2] = '{1'b1, 127,  10,   6,    8'hFF, 1'b0};  // short: 4 pad beats
      vecs[3] = '{1'b1, 127,  4,    8,    8'hFF, 1'b0};  // long: 4 dumped
      vecs[4] = '{1'b1, 0,    5,    5,    8'h03, 1'b1};  // 1-qword fragments with gaps
      vecs[5] = '{1'b1, 3,    8,    8,    8'h7F, 1'b1};  // exact multiple of fragment size
      vecs[6] = '{1'b1, 127,  0,    1,    8'hFF, 1'b0};  // zero length: malformed
      vecs[7] = '{1'b1, 3,    10,   4,    8'hFF, 1'b0};  // short ending on fragment boundary
      vecs[8] = '{1'b1, 1023, 1100, 1100, 8'h01, 1'b0};  // largest fragment size
      fresh   = '{1'b1, 2,    7,    7,    8'h3F, 1'b0};

      areset = 1'b1;
      s_evhdr_tdata = '0; s_evhdr_tvalid = 1'b0;
      s_evdata_tdata = '0; s_evdata_tkeep = '0; s_evdata_tlast = 1'b0; s_evdata_tvalid = 1'b0;
      m_udphdr_tready = 1'b1; m_udpdata_tready = 1'b1;
      nfragment_count_i = '0; event_ip_i = '0; event_port_i = '0; event_open_i = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      check("reset_handshakes", 64'({s_evhdr_tready, s_evdata_tready, m_udphdr_tvalid, m_udpdata_tvalid, busy_o}), 64'd0);
      check("reset_counters", 64'({drop_count_o, err_count_o}), 64'd0);
      areset = 1'b0;
      #1;
      check("idle_hdr_ready", 64'(s_evhdr_tready), 64'd1);
      @(posedge aclk); #1;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // reset while payload is flowing
      event_ip_i = 32'h0A000001; event_port_i = 16'd7000; event_open_i = 1'b1; nfragment_count_i = 10'd127;
      model_event(1'b1, 127, 20, 20, 8'hFF, 32'h2000, 32'h0A000001, 16'd7000);
      fork
         send_hdr(32'h2000, 20'd20);
         send_data(32'h2000, 20, 3, 8'hFF, 1'b0);
      join
      check("midpkt_busy", 64'(busy_o), 64'd1);
      areset = 1'b1;
      @(posedge aclk); #1;
      check("midpkt_reset_valids", 64'({m_udphdr_tvalid, m_udpdata_tvalid, s_evdata_tready, busy_o}), 64'd0);
      check("midpkt_reset_counters", 64'({drop_count_o, err_count_o}), 64'd0);
      hq.delete(); dq.delete(); exp_drop = 0; exp_err = 0;
      areset = 1'b0;
      @(posedge aclk); #1;
      run_vec(fresh, 9);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // hard stop so a wedged design still produces a verdict
   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "global timeout");
   end

endmodule
